id_ex_stage: RTL and testbench
==============================

Name: id_ex_stage

Overview:
- ID→EX pipeline register for the single-issue RV32I core.
- Latches decoded operands and ALU control from decode, and resolves RAW hazards by forwarding from the EX/MEM and MEM/WB stages.
- Inserts load-use bubbles and presents the final a/b/aluc operands to the execute ALU with a valid/ready handshake.

Parameters:
XLEN, 32, datapath width
RAW, 5, register-address width

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
in_valid  in  1  decode has an instruction
in_ready  out  1  stage can accept this cycle
in_pc  in  XLEN  instruction PC
in_rs1_addr, in_rs2_addr  in  RAW  source register indices
in_rs1_data, in_rs2_data  in  XLEN  register-file read data
in_imm  in  XLEN  sign-extended immediate
in_a_sel_pc  in  1  ALU a = pc instead of rs1
in_b_sel_imm  in  1  ALU b = imm instead of rs2
in_aluc  in  4  ALU control code
in_rd_addr  in  RAW  destination index
in_rd_wen  in  1  writes rd
in_is_load  in  1  instruction is a load
flush  in  1  kill held and incoming instruction (branch redirect)
exm_valid, exm_rd_wen, exm_is_load  in  1  EX/MEM slot status
exm_rd_addr  in  RAW  EX/MEM destination
exm_result  in  XLEN  EX/MEM ALU result
wb_valid, wb_rd_wen  in  1  MEM/WB slot status
wb_rd_addr  in  RAW  MEM/WB destination
wb_result  in  XLEN  MEM/WB writeback value
out_valid  out  1  operands valid for EX
out_ready  in  1  EX consumes this cycle
alu_a, alu_b  out  XLEN  ALU operands
alu_aluc  out  4  ALU control
out_pc  out  XLEN  held PC
out_store_data  out  XLEN  forwarded rs2, always (for stores)
out_rd_addr  out  RAW  held rd
out_rd_wen  out  1  held rd write enable, gated by out_valid
out_is_load  out  1  held load flag

Behaviour:
- Reset (async, rst=1):
  - v_q=0; all held fields are 0; out_valid=0.
  - Reset mid-handshake drops the instruction.
- in_ready = !v_q || (out_valid && out_ready). Load by itself can be accepted (pure register, no skid buffer).
- Accept: when in_valid && in_ready, all in_* fields are registered next edge and v_q=1.
- Empty: if the held instruction is consumed with no accept, v_q=0 next edge.
- Forwarding on held rs1/rs2, combinational every cycle, so values stay correct while stalled:
  - Index 0 is never forwarded; result is 0 when rs_addr=0.
  - Priority 1: EX/MEM hit when exm_valid && exm_rd_wen && exm_rd_addr==rs && !exm_is_load → exm_result.
  - Priority 2: otherwise MEM/WB hit when wb_valid && wb_rd_wen && wb_rd_addr==rs → wb_result.
  - Otherwise the latched register-file data.
- Operand select:
  - alu_a = a_sel_pc ? pc : fwd_rs1.
  - alu_b = b_sel_imm ? imm : fwd_rs2.
- Load-use hazard: exm_valid && exm_is_load && exm_rd_wen && exm_rd_addr!=0 && the address matches a *used* source.
  - rs1 is used iff !a_sel_pc.
  - rs2 is used iff !b_sel_imm or the instruction is a store.
- Store decode: stores are flagged by decode setting rd_wen=0 with b_sel_imm=1; rs2 is treated as used whenever rd_wen=0.
- out_valid = v_q && !hazard: a bubble is presented and the stage holds; hazard clears after one cycle.
- Flush:
  - Next edge v_q=0 and any simultaneous accept is discarded; flush beats in_valid.
  - in_ready may still be 1, but the accepted instruction is squashed.
- When out_valid=0, out_rd_wen=0.
- alu_aluc passes the held code unchanged. No arithmetic is done here; all widths are XLEN with no extension.

Optional Feature:
- Macro: IDEX_PERF_CNT_EN.
- When defined, adds outputs perf_bubble_cnt[31:0] and perf_stall_cnt[31:0]:
  - perf_bubble_cnt counts cycles with v_q && hazard.
  - perf_stall_cnt counts cycles with out_valid && !out_ready.
  - Both wrap at 2^32 and reset to 0.
- Undefined: no ports, no counter logic.

Decomposition:
- core_pkg holds the ALU control constants:
  - ALU_ADD=4'b0000, ALU_SUB=4'b1000, ALU_SLL=4'b0001
  - ALU_SLT=4'b0010, ALU_SLTU=4'b1010, ALU_PASSB=4'b0011
  - ALU_XOR=4'b0100, ALU_SRL=4'b0101, ALU_SRA=4'b1101
  - ALU_OR=4'b0110, ALU_AND=4'b0111
  - XLEN/RAW defaults
- One sub-module, fwd_mux, instantiated twice: rs address + latched data + both bypass ports → forwarded value.

Test Plan:
- Basic flow: accept add rs1=x1(5), rs2=x2(7), aluc=ALU_ADD with no hazards → next cycle out_valid=1, alu_a=5, alu_b=7, alu_aluc=0000.
- EX/MEM priority: EX/MEM writes x1=0x10 and MEM/WB writes x1=0x20 simultaneously → alu_a=0x10; drop the EX/MEM hit → alu_a=0x20.
- x0 bypass: rs1=x0 while exm_rd_addr=0 with result 0xFFFF → alu_a=0.
- Load-use: held rs2=x3 with b_sel_imm=0, and EX/MEM is a load to x3 → out_valid=0 and in_ready=0 for 1 cycle; next cycle MEM/WB supplies x3=0xAB → alu_b=0xAB, out_valid=1.
- Backpressure plus flush: out_ready=0 for 3 cycles → outputs stable and in_ready=0; flush with in_valid=1 → next cycle out_valid=0.
- Mid-operation reset: assert rst with v_q=1 → out_valid=0 immediately, all outputs 0. With IDEX_PERF_CNT_EN defined, counters read 0.

Source files
------------

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: ALU control codes,
// datapath defaults and small decode helpers.
package core_pkg;

  localparam int XLEN_DEF = 32;
  localparam int RAW_DEF  = 5;

  localparam logic [3:0] ALU_ADD   = 4'b0000;
  localparam logic [3:0] ALU_SUB   = 4'b1000;
  localparam logic [3:0] ALU_SLL   = 4'b0001;
  localparam logic [3:0] ALU_SLT   = 4'b0010;
  localparam logic [3:0] ALU_SLTU  = 4'b1010;
  localparam logic [3:0] ALU_PASSB = 4'b0011;
  localparam logic [3:0] ALU_XOR   = 4'b0100;
  localparam logic [3:0] ALU_SRL   = 4'b0101;
  localparam logic [3:0] ALU_SRA   = 4'b1101;
  localparam logic [3:0] ALU_OR    = 4'b0110;
  localparam logic [3:0] ALU_AND   = 4'b0111;

  // Stores carry rd_wen=0, and their rs2 is the store data.
  function automatic logic rs2_used(
    input logic b_sel_imm,
    input logic rd_wen
  );
    return !b_sel_imm || !rd_wen;
  endfunction

  function automatic logic rs1_used(
    input logic a_sel_pc
  );
    return !a_sel_pc;
  endfunction

endpackage

// File: rtl/id_ex_stage_fwd_mux.sv
// Operand bypass mux: EX/MEM beats MEM/WB beats the
// latched register-file value; x0 always reads zero.
module fwd_mux
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF
) (
  input  logic [RAW-1:0]  rs_addr,
  input  logic [XLEN-1:0] rf_data,
  input  logic            exm_valid,
  input  logic            exm_rd_wen,
  input  logic            exm_is_load,
  input  logic [RAW-1:0]  exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_valid,
  input  logic            wb_rd_wen,
  input  logic [RAW-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic [XLEN-1:0] fwd_data
);

  logic zero;
  logic exm_hit;
  logic wb_hit;

  assign zero = (rs_addr == '0);

  // A load in EX/MEM has no data yet; the hazard
  // logic stalls instead of bypassing it.
  assign exm_hit = exm_valid && exm_rd_wen
                && !exm_is_load
                && (exm_rd_addr == rs_addr);

  assign wb_hit = wb_valid && wb_rd_wen
               && (wb_rd_addr == rs_addr);

  always_comb begin
    fwd_data = rf_data;
    priority case (1'b1)
      zero:    fwd_data = '0;
      exm_hit: fwd_data = exm_result;
      wb_hit:  fwd_data = wb_result;
      default: fwd_data = rf_data;
    endcase
  end

endmodule

// File: rtl/id_ex_stage.sv
// ID->EX pipeline register with bypass and load-use stall.
// Optional IDEX_PERF_CNT_EN adds bubble/stall counters.
module id_ex_stage
  import core_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int RAW  = RAW_DEF
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [RAW-1:0]  in_rs1_addr,
  input  logic [RAW-1:0]  in_rs2_addr,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic            in_a_sel_pc,
  input  logic            in_b_sel_imm,
  input  logic [3:0]      in_aluc,
  input  logic [RAW-1:0]  in_rd_addr,
  input  logic            in_rd_wen,
  input  logic            in_is_load,
  input  logic            flush,
  input  logic            exm_valid,
  input  logic            exm_rd_wen,
  input  logic            exm_is_load,
  input  logic [RAW-1:0]  exm_rd_addr,
  input  logic [XLEN-1:0] exm_result,
  input  logic            wb_valid,
  input  logic            wb_rd_wen,
  input  logic [RAW-1:0]  wb_rd_addr,
  input  logic [XLEN-1:0] wb_result,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] alu_a,
  output logic [XLEN-1:0] alu_b,
  output logic [3:0]      alu_aluc,
  output logic [XLEN-1:0] out_pc,
  output logic [XLEN-1:0] out_store_data,
  output logic [RAW-1:0]  out_rd_addr,
  output logic            out_rd_wen,
  output logic            out_is_load
`ifdef IDEX_PERF_CNT_EN
  ,
  output logic [31:0]     perf_bubble_cnt,
  output logic [31:0]     perf_stall_cnt
`endif
);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic [RAW-1:0]  rs1_addr;
    logic [RAW-1:0]  rs2_addr;
    logic [RAW-1:0]  rd_addr;
    logic            a_sel_pc;
    logic            b_sel_imm;
    logic [3:0]      aluc;
    logic            rd_wen;
    logic            is_load;
  } id_ex_t;

  id_ex_t          q;
  id_ex_t          d;
  logic            v_q;
  logic            hazard;
  logic            accept;
  logic            fire;
  logic            ld_pending;
  logic            hit1;
  logic            hit2;
  logic [XLEN-1:0] fwd_rs1;
  logic [XLEN-1:0] fwd_rs2;

  always_comb begin
    d          = '0;
    d.pc       = in_pc;
    d.rs1_data = in_rs1_data;
    d.rs2_data = in_rs2_data;
    d.imm      = in_imm;
    d.rs1_addr = in_rs1_addr;
    d.rs2_addr = in_rs2_addr;
    d.rd_addr  = in_rd_addr;
    d.a_sel_pc = in_a_sel_pc;
    d.b_sel_imm = in_b_sel_imm;
    d.aluc     = in_aluc;
    d.rd_wen   = in_rd_wen;
    d.is_load  = in_is_load;
  end

  fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd1 (
    .rs_addr     (q.rs1_addr),
    .rf_data     (q.rs1_data),
    .exm_valid   (exm_valid),
    .exm_rd_wen  (exm_rd_wen),
    .exm_is_load (exm_is_load),
    .exm_rd_addr (exm_rd_addr),
    .exm_result  (exm_result),
    .wb_valid    (wb_valid),
    .wb_rd_wen   (wb_rd_wen),
    .wb_rd_addr  (wb_rd_addr),
    .wb_result   (wb_result),
    .fwd_data    (fwd_rs1)
  );

  fwd_mux #(.XLEN(XLEN), .RAW(RAW)) u_fwd2 (
    .rs_addr     (q.rs2_addr),
    .rf_data     (q.rs2_data),
    .exm_valid   (exm_valid),
    .exm_rd_wen  (exm_rd_wen),
    .exm_is_load (exm_is_load),
    .exm_rd_addr (exm_rd_addr),
    .exm_result  (exm_result),
    .wb_valid    (wb_valid),
    .wb_rd_wen   (wb_rd_wen),
    .wb_rd_addr  (wb_rd_addr),
    .wb_result   (wb_result),
    .fwd_data    (fwd_rs2)
  );

  assign ld_pending = exm_valid && exm_is_load
                   && exm_rd_wen
                   && (exm_rd_addr != '0);

  assign hit1 = rs1_used(q.a_sel_pc)
             && (exm_rd_addr == q.rs1_addr);

  assign hit2 = rs2_used(q.b_sel_imm, q.rd_wen)
             && (exm_rd_addr == q.rs2_addr);

  assign hazard    = ld_pending && (hit1 || hit2);
  assign out_valid = v_q && !hazard;
  assign fire      = out_valid && out_ready;
  assign in_ready  = !v_q || fire;
  assign accept    = in_valid && in_ready;

  // Flush wins over accept so a redirect squashes
  // both the held and the incoming instruction.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q <= 1'b0;
      q   <= '0;
    end else if (flush) begin
      v_q <= 1'b0;
    end else if (accept) begin
      v_q <= 1'b1;
      q   <= d;
    end else if (fire) begin
      v_q <= 1'b0;
    end
  end

  assign alu_a = q.a_sel_pc ? q.pc : fwd_rs1;
  assign alu_b = q.b_sel_imm ? q.imm : fwd_rs2;

  assign alu_aluc       = q.aluc;
  assign out_pc         = q.pc;
  assign out_store_data = fwd_rs2;
  assign out_rd_addr    = q.rd_addr;
  assign out_rd_wen     = q.rd_wen && out_valid;
  assign out_is_load    = q.is_load;

`ifdef IDEX_PERF_CNT_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      perf_bubble_cnt <= '0;
      perf_stall_cnt  <= '0;
    end else begin
      if (v_q && hazard)
        perf_bubble_cnt <= perf_bubble_cnt + 32'd1;
      if (out_valid && !out_ready)
        perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed bench for id_ex_stage: flow, bypass priority,
// load-use bubble, backpressure, flush and async reset.
module tb_id_ex_stage;
  import core_pkg::*;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_pc;
  logic [4:0]  in_rs1_addr;
  logic [4:0]  in_rs2_addr;
  logic [31:0] in_rs1_data;
  logic [31:0] in_rs2_data;
  logic [31:0] in_imm;
  logic        in_a_sel_pc;
  logic        in_b_sel_imm;
  logic [3:0]  in_aluc;
  logic [4:0]  in_rd_addr;
  logic        in_rd_wen;
  logic        in_is_load;
  logic        flush;
  logic        exm_valid;
  logic        exm_rd_wen;
  logic        exm_is_load;
  logic [4:0]  exm_rd_addr;
  logic [31:0] exm_result;
  logic        wb_valid;
  logic        wb_rd_wen;
  logic [4:0]  wb_rd_addr;
  logic [31:0] wb_result;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [3:0]  alu_aluc;
  logic [31:0] out_pc;
  logic [31:0] out_store_data;
  logic [4:0]  out_rd_addr;
  logic        out_rd_wen;
  logic        out_is_load;
`ifdef IDEX_PERF_CNT_EN
  logic [31:0] perf_bubble_cnt;
  logic [31:0] perf_stall_cnt;
`endif

  int n_chk;
  int n_pass;

  id_ex_stage dut (
    .clk            (clk),
    .rst            (rst),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pc          (in_pc),
    .in_rs1_addr    (in_rs1_addr),
    .in_rs2_addr    (in_rs2_addr),
    .in_rs1_data    (in_rs1_data),
    .in_rs2_data    (in_rs2_data),
    .in_imm         (in_imm),
    .in_a_sel_pc    (in_a_sel_pc),
    .in_b_sel_imm   (in_b_sel_imm),
    .in_aluc        (in_aluc),
    .in_rd_addr     (in_rd_addr),
    .in_rd_wen      (in_rd_wen),
    .in_is_load     (in_is_load),
    .flush          (flush),
    .exm_valid      (exm_valid),
    .exm_rd_wen     (exm_rd_wen),
    .exm_is_load    (exm_is_load),
    .exm_rd_addr    (exm_rd_addr),
    .exm_result     (exm_result),
    .wb_valid       (wb_valid),
    .wb_rd_wen      (wb_rd_wen),
    .wb_rd_addr     (wb_rd_addr),
    .wb_result      (wb_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .alu_a          (alu_a),
    .alu_b          (alu_b),
    .alu_aluc       (alu_aluc),
    .out_pc         (out_pc),
    .out_store_data (out_store_data),
    .out_rd_addr    (out_rd_addr),
    .out_rd_wen     (out_rd_wen),
    .out_is_load    (out_is_load)
`ifdef IDEX_PERF_CNT_EN
    ,
    .perf_bubble_cnt (perf_bubble_cnt),
    .perf_stall_cnt  (perf_stall_cnt)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(
    input logic [31:0] pc,
    input logic [4:0]  r1a,
    input logic [31:0] r1d,
    input logic [4:0]  r2a,
    input logic [31:0] r2d,
    input logic [31:0] imm,
    input logic        asel,
    input logic        bsel,
    input logic [3:0]  aluc,
    input logic [4:0]  rd,
    input logic        wen,
    input logic        ld
  );
    in_valid     = 1'b1;
    in_pc        = pc;
    in_rs1_addr  = r1a;
    in_rs1_data  = r1d;
    in_rs2_addr  = r2a;
    in_rs2_data  = r2d;
    in_imm       = imm;
    in_a_sel_pc  = asel;
    in_b_sel_imm = bsel;
    in_aluc      = aluc;
    in_rd_addr   = rd;
    in_rd_wen    = wen;
    in_is_load   = ld;
  endtask

  task automatic clr_byp();
    exm_valid   = 1'b0;
    exm_rd_wen  = 1'b0;
    exm_is_load = 1'b0;
    exm_rd_addr = '0;
    exm_result  = '0;
    wb_valid    = 1'b0;
    wb_rd_wen   = 1'b0;
    wb_rd_addr  = '0;
    wb_result   = '0;
  endtask

  initial begin
    n_chk = 0;
    n_pass = 0;
    rst = 1'b1;
    flush = 1'b0;
    out_ready = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    in_valid = 1'b0;
    clr_byp();
    #12;
    chk("rst_valid", 32'(out_valid), 0);
    chk("rst_ready", 32'(in_ready), 1);
    chk("rst_a", alu_a, 0);
    rst = 1'b0;
    tick();

    // basic add x1(5) + x2(7)
    drive(32'h40, 1, 5, 2, 7, 0, 0, 0, ALU_ADD, 3, 1, 0);
    chk("acc_ready", 32'(in_ready), 1);
    tick();
    in_valid = 1'b0;
    #1;
    chk("add_valid", 32'(out_valid), 1);
    chk("add_a", alu_a, 5);
    chk("add_b", alu_b, 7);
    chk("add_aluc", 32'(alu_aluc), 0);
    chk("add_pc", out_pc, 32'h40);
    chk("add_rd", 32'(out_rd_addr), 3);
    chk("add_wen", 32'(out_rd_wen), 1);

    // EX/MEM beats MEM/WB on x1
    exm_valid = 1; exm_rd_wen = 1;
    exm_rd_addr = 1; exm_result = 32'h10;
    wb_valid = 1; wb_rd_wen = 1;
    wb_rd_addr = 1; wb_result = 32'h20;
    #1;
    chk("prio_exm", alu_a, 32'h10);
    chk("prio_sd", out_store_data, 7);
    exm_valid = 0;
    #1;
    chk("prio_wb", alu_a, 32'h20);
    clr_byp();
    tick();
    chk("drain_valid", 32'(out_valid), 0);
    chk("drain_wen", 32'(out_rd_wen), 0);

    // x0 never bypassed; load to x0 no hazard
    drive(32'h44, 0, 32'h123, 5, 9, 32'h44,
          0, 1, ALU_SUB, 4, 1, 0);
    tick();
    in_valid = 1'b0;
    exm_valid = 1; exm_rd_wen = 1;
    exm_rd_addr = 0; exm_result = 32'hFFFF;
    wb_valid = 1; wb_rd_wen = 1;
    wb_rd_addr = 0; wb_result = 32'hFFFF;
    #1;
    chk("x0_a", alu_a, 0);
    chk("x0_b", alu_b, 32'h44);
    chk("x0_aluc", 32'(alu_aluc), 32'h8);
    chk("x0_sd", out_store_data, 9);
    exm_is_load = 1;
    #1;
    chk("x0_ld_valid", 32'(out_valid), 1);
    clr_byp();
    tick();

    // load-use on rs2=x3
    drive(32'h48, 4, 1, 3, 32'h55, 0,
          0, 0, ALU_OR, 6, 1, 0);
    tick();
    in_valid = 1'b0;
    exm_valid = 1; exm_rd_wen = 1;
    exm_is_load = 1; exm_rd_addr = 3;
    #1;
    chk("lu_valid", 32'(out_valid), 0);
    chk("lu_ready", 32'(in_ready), 0);
    chk("lu_wen", 32'(out_rd_wen), 0);
    tick();
    clr_byp();
    wb_valid = 1; wb_rd_wen = 1;
    wb_rd_addr = 3; wb_result = 32'hAB;
    #1;
    chk("lu_b", alu_b, 32'hAB);
    chk("lu_valid2", 32'(out_valid), 1);
    chk("lu_ready2", 32'(in_ready), 1);
    tick();
    clr_byp();

    // backpressure, then flush with in_valid
    drive(32'h100, 7, 32'h77, 0, 0, 8,
          1, 1, ALU_ADD, 9, 1, 1);
    tick();
    out_ready = 1'b0;
    drive(32'h200, 1, 1, 1, 1, 1, 0, 0, ALU_AND, 1, 1, 0);
    for (int i = 0; i < 3; i++) begin
      #1;
      chk("bp_valid", 32'(out_valid), 1);
      chk("bp_ready", 32'(in_ready), 0);
      chk("bp_a", alu_a, 32'h100);
      chk("bp_b", alu_b, 8);
      chk("bp_pc", out_pc, 32'h100);
      chk("bp_ld", 32'(out_is_load), 1);
      tick();
    end
    out_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fl_ready", 32'(in_ready), 1);
    tick();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    chk("fl_valid", 32'(out_valid), 0);
    chk("fl_wen", 32'(out_rd_wen), 0);
`ifdef IDEX_PERF_CNT_EN
    chk("perf_bubble", perf_bubble_cnt, 1);
    chk("perf_stall", perf_stall_cnt, 3);
`endif

    // async reset while holding
    drive(32'h300, 1, 5, 2, 6, 0, 0, 0, ALU_XOR, 2, 1, 0);
    tick();
    in_valid = 1'b0;
    #1;
    chk("pre_rst_valid", 32'(out_valid), 1);
    rst = 1'b1;
    #1;
    chk("mr_valid", 32'(out_valid), 0);
    chk("mr_a", alu_a, 0);
    chk("mr_b", alu_b, 0);
    chk("mr_pc", out_pc, 0);
    chk("mr_aluc", 32'(alu_aluc), 0);
    chk("mr_rd", 32'(out_rd_addr), 0);
    chk("mr_wen", 32'(out_rd_wen), 0);
`ifdef IDEX_PERF_CNT_EN
    chk("mr_bubble", perf_bubble_cnt, 0);
    chk("mr_stall", perf_stall_cnt, 0);
`endif
    tick();
    rst = 1'b0;
    tick();
    chk("post_rst_valid", 32'(out_valid), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
